lifo_host: RTL and testbench
============================

LIFO_HOST -- requirements
Module: lifo_host

Interface
REQ-001 SETUP_CYC, 1, clocks that stk_push/stk_pop/stk_data_in are stable before the stk_enable rise (range 1-15).
REQ-002 PULSE_CYC, 2, clocks that stk_enable or the clear pulse on stk_rst stays high (range 1-15).
REQ-003 HOLD_CYC, 1, clocks that stk_push/stk_pop/stk_data_in stay stable after the stk_enable fall, before stack outputs are sampled (range 1-15).
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when both valid and ready are high at a clk edge.
REQ-008 cmd_op  in  2  00 PUSH, 01 POP, 10 DRAIN, 11 CLEAR.
REQ-009 cmd_data  in  4  value to push; ignored for other ops.
REQ-010 rsp_valid  out  1  response offered.
REQ-011 rsp_ready  in  1  response consumed when both valid and ready are high.
REQ-012 rsp_data  out  4  popped value; 0 for PUSH, CLEAR and failed ops.
REQ-013 rsp_status  out  2  00 OK, 01 INVALID, 10 EMPTY.
REQ-014 rsp_last  out  1  final response of a command.
REQ-015 stk_rst, stk_enable, stk_push, stk_pop  out  1 each  stack control lines.
REQ-016 stk_data_in  out  4  stack write data.
REQ-017 stk_data_out  in  4; stk_empty, stk_full, stk_invalid  in  1 each  stack outputs.

Function
REQ-018 The block SHALL use the FSM states IDLE, SETUP, PULSE, HOLD, SAMPLE, RESP and CLR.
REQ-019 cmd_ready SHALL be 1 only in IDLE with rst low; the block SHALL accept one command at a time.
REQ-020 On PUSH or POP, the block SHALL capture op/data, drive stk_push or stk_pop (never both), and go IDLE->SETUP.
REQ-021 SETUP SHALL last SETUP_CYC clocks, PULSE SHALL last PULSE_CYC clocks with stk_enable=1, and HOLD SHALL last HOLD_CYC clocks; then the FSM SHALL go to SAMPLE for 1 clock.
REQ-022 stk_enable SHALL be registered, glitch-free, and high only in PULSE.
REQ-023 stk_push, stk_pop and stk_data_in SHALL be constant from SETUP entry through SAMPLE.
REQ-024 SAMPLE SHALL set rsp_status to INVALID if stk_invalid=1, else OK; rsp_data SHALL equal stk_data_out for an OK POP.
REQ-025 RESP SHALL hold rsp_valid and all rsp_* signals stable until rsp_ready; the handshake clock SHALL return the FSM to IDLE, or to SETUP for a continuing DRAIN.
REQ-026 DRAIN with stk_empty=1 at acceptance SHALL produce no enable pulse and exactly one response: EMPTY, data 0, last 1.
REQ-027 Otherwise DRAIN SHALL repeat POP cycles, emitting one OK response per value, with rsp_last=1 on the response whose SAMPLE saw stk_empty=1.
REQ-028 A DRAIN iteration that samples stk_invalid=1 SHALL respond INVALID with last 1 and terminate.
REQ-029 CLEAR SHALL drive stk_rst high for PULSE_CYC clocks in state CLR, then respond OK with last 1.
REQ-030 Total latency from PUSH/POP acceptance to rsp_valid SHALL be SETUP_CYC+PULSE_CYC+HOLD_CYC+1 clocks.

Reset
REQ-031 While rst=1, stk_rst SHALL be 1 combinationally, stk_enable SHALL be 0 immediately, and the FSM SHALL be IDLE.
REQ-032 While rst=1, all other registered outputs SHALL be 0 and cmd_ready SHALL be 0.
REQ-033 rst mid-operation SHALL abort the command with no response issued.

Structure
REQ-034 The package lifo_pkg SHALL hold the op codes, status codes, FSM state enum and STACK_DEPTH=8.
REQ-035 One sub-module, lifo_host_timer, SHALL be used: a 4-bit loadable down-counter with a done flag, shared by the SETUP/PULSE/HOLD/CLR phases.

Verification
REQ-036 PUSH 4'hA on an empty stack -> stk_push=1 with data A held for 5 clocks, stk_enable high for exactly 2 clocks, response OK/0/last.
REQ-037 PUSH 3, PUSH 7, then POP -> POP response OK with data 7; response arrives 5 clocks after acceptance.
REQ-038 9 PUSHes of values 0-8 -> responses 1-8 OK, 9th INVALID.
REQ-039 PUSH 1,2,3 then DRAIN -> responses 3, 2, 1 all OK, last only on 1; a following DRAIN gives EMPTY/last with no enable pulse.
REQ-040 rsp_ready held low 10 clocks during POP -> rsp_* stable and cmd_ready=0 throughout.
REQ-041 rst asserted during PULSE -> stk_enable falls the same cycle, stk_rst=1, no response, and cmd_ready=1 one clock after release.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared codes and FSM state type for the LIFO stack host.
package lifo_pkg;

  localparam int unsigned STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_DRAIN = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_INVALID = 2'b01,
    STAT_EMPTY   = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_SAMPLE,
    S_RESP,
    S_CLR
  } state_e;

endpackage

// File: rtl/lifo_host_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
module lifo_host_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 4'd1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lifo_host.sv
// Command/response host that sequences an external stack through
// setup / enable-pulse / hold / sample phases.
module lifo_host
  import lifo_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [1:0] rsp_status,
  output logic       rsp_last,
  output logic       stk_rst,
  output logic       stk_enable,
  output logic       stk_push,
  output logic       stk_pop,
  output logic [3:0] stk_data_in,
  input  logic [3:0] stk_data_out,
  input  logic       stk_empty,
  input  logic       stk_full,
  input  logic       stk_invalid
);

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic       push_q, push_d, pop_q, pop_d;
  logic [3:0] din_q, din_d;
  logic       en_q, en_d, clr_q, clr_d;
  logic       rv_q, rv_d, last_q, last_d;
  logic [3:0] rdata_q, rdata_d;
  status_e    rstat_q, rstat_d;
  logic       tmr_load, tmr_done;
  logic [3:0] tmr_val;
  logic       unused_full;

  assign unused_full = stk_full;

  lifo_host_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state, phase timer loads and registered-output next values.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    push_d   = push_q;
    pop_d    = pop_q;
    din_d    = din_q;
    rv_d     = rv_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    rstat_d  = rstat_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = op_e'(cmd_op);
          case (op_e'(cmd_op))
            OP_PUSH: begin
              push_d   = 1'b1;
              pop_d    = 1'b0;
              din_d    = cmd_data;
              state_d  = S_SETUP;
              tmr_load = 1'b1;
              tmr_val  = SETUP_LD;
            end
            OP_POP: begin
              push_d   = 1'b0;
              pop_d    = 1'b1;
              state_d  = S_SETUP;
              tmr_load = 1'b1;
              tmr_val  = SETUP_LD;
            end
            OP_DRAIN: begin
              if (stk_empty) begin
                rv_d    = 1'b1;
                rstat_d = STAT_EMPTY;
                rdata_d = '0;
                last_d  = 1'b1;
                state_d = S_RESP;
              end else begin
                push_d   = 1'b0;
                pop_d    = 1'b1;
                state_d  = S_SETUP;
                tmr_load = 1'b1;
                tmr_val  = SETUP_LD;
              end
            end
            default: begin
              state_d  = S_CLR;
              tmr_load = 1'b1;
              tmr_val  = PULSE_LD;
            end
          endcase
        end
      end
      S_SETUP: begin
        if (tmr_done) begin
          state_d  = S_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      S_PULSE: begin
        if (tmr_done) begin
          state_d  = S_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (tmr_done) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        state_d = S_RESP;
        rv_d    = 1'b1;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        if (stk_invalid) begin
          rstat_d = STAT_INVALID;
          rdata_d = '0;
          last_d  = 1'b1;
        end else begin
          rstat_d = STAT_OK;
          rdata_d = (op_q == OP_PUSH) ? 4'd0 : stk_data_out;
          last_d  = (op_q == OP_DRAIN) ? stk_empty : 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          rdata_d = '0;
          rstat_d = STAT_OK;
          last_d  = 1'b0;
          // A drain keeps popping until a response was marked last.
          if (op_q == OP_DRAIN && !last_q) begin
            pop_d    = 1'b1;
            state_d  = S_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CLR: begin
        if (tmr_done) begin
          state_d = S_RESP;
          rv_d    = 1'b1;
          rstat_d = STAT_OK;
          rdata_d = '0;
          last_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    en_d  = (state_d == S_PULSE);
    clr_d = (state_d == S_CLR);
  end

  // State and registered-output flops; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      din_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      rv_q    <= 1'b0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      rstat_q <= STAT_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      din_q   <= din_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      rv_q    <= rv_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      rstat_q <= rstat_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign stk_rst     = rst | clr_q;
  assign stk_enable  = en_q;
  assign stk_push    = push_q;
  assign stk_pop     = pop_q;
  assign stk_data_in = din_q;
  assign rsp_valid   = rv_q;
  assign rsp_data    = rdata_q;
  assign rsp_status  = rstat_q;
  assign rsp_last    = last_q;

endmodule

// File: tb/tb_lifo_host.sv
// Directed bench for lifo_host with a behavioural 8-deep stack attached.
module tb_lifo_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic [1:0] rsp_status;
  logic       rsp_last;
  logic       stk_rst, stk_enable, stk_push, stk_pop;
  logic [3:0] stk_data_in;
  logic [3:0] stk_data_out;
  logic       stk_empty, stk_full, stk_invalid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lifo_host #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_last(rsp_last),
    .stk_rst(stk_rst), .stk_enable(stk_enable), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_invalid(stk_invalid)
  );

  // Behavioural stack: acts once on the first clock edge that sees enable high.
  logic [3:0] mem [8];
  int         sp = 0;
  logic       en_prev = 1'b0;
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == 8);
  always @(posedge clk) begin
    if (stk_rst) begin
      sp           <= 0;
      stk_invalid  <= 1'b0;
      stk_data_out <= '0;
      en_prev      <= 1'b0;
    end else begin
      en_prev <= stk_enable;
      if (stk_enable && !en_prev) begin
        if (stk_push) begin
          if (sp == 8) stk_invalid <= 1'b1;
          else begin
            mem[sp]     <= stk_data_in;
            sp          <= sp + 1;
            stk_invalid <= 1'b0;
          end
        end else if (stk_pop) begin
          if (sp == 0) stk_invalid <= 1'b1;
          else begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
            stk_invalid  <= 1'b0;
          end
        end
      end
    end
  end

  // Activity counters sampled mid-cycle.
  int en_cnt = 0, push_cnt = 0, both_cnt = 0, din_bad = 0, clr_cnt = 0, rv_cnt = 0;
  logic [3:0] din_exp = '0;
  always @(negedge clk) begin
    en_cnt   += int'(stk_enable);
    push_cnt += int'(stk_push);
    both_cnt += int'(stk_push && stk_pop);
    if (stk_push && stk_data_in !== din_exp) din_bad++;
    if (stk_rst && !rst) clr_cnt++;
    rv_cnt += int'(rsp_valid);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offer a command at a falling edge and return just after its acceptance edge.
  task automatic send(input logic [1:0] op, input logic [3:0] data);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Clocks from acceptance until rsp_valid (50 means it never came).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, bad;
    logic [3:0] hd; logic [1:0] hs; logic hl;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_stk_rst", stk_rst, 1);
    chk("rst_stk_enable", stk_enable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_stk_push", stk_push, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_stk_rst", stk_rst, 0);

    // PUSH A on empty stack
    en_cnt = 0; push_cnt = 0; din_exp = 4'hA;
    send(2'b00, 4'hA);
    wait_rsp(lat);
    chk("pushA_latency", lat, 5);
    chk("pushA_status", rsp_status, 2'b00);
    chk("pushA_data", rsp_data, 0);
    chk("pushA_last", rsp_last, 1);
    consume();
    chk("pushA_en_cycles", en_cnt, 2);
    chk("pushA_push_cycles", push_cnt, 5);
    chk("pushA_din_held", din_bad, 0);

    // PUSH 3, PUSH 7, POP
    din_exp = 4'h3; send(2'b00, 4'h3); wait_rsp(lat); consume();
    din_exp = 4'h7; send(2'b00, 4'h7); wait_rsp(lat); consume();
    send(2'b01, 4'h0);
    wait_rsp(lat);
    chk("pop7_latency", lat, 5);
    chk("pop7_status", rsp_status, 2'b00);
    chk("pop7_data", rsp_data, 7);
    chk("pop7_last", rsp_last, 1);
    consume();

    // POP with rsp_ready held low for 10 clocks
    din_exp = 4'h5; send(2'b00, 4'h5); wait_rsp(lat); consume();
    send(2'b01, 4'h0);
    wait_rsp(lat);
    hd = rsp_data; hs = rsp_status; hl = rsp_last; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== hd || rsp_status !== hs || rsp_last !== hl || cmd_ready)
        bad++;
    end
    chk("stall_stable", bad, 0);
    chk("stall_data", hd, 5);
    consume();

    // CLEAR
    clr_cnt = 0;
    send(2'b11, 4'h0);
    wait_rsp(lat);
    chk("clear_status", rsp_status, 2'b00);
    chk("clear_last", rsp_last, 1);
    chk("clear_data", rsp_data, 0);
    chk("clear_rst_cycles", clr_cnt, 2);
    consume();

    // Nine pushes into an 8-deep stack
    for (int i = 0; i < 9; i++) begin
      din_exp = 4'(i);
      send(2'b00, 4'(i));
      wait_rsp(lat);
      if (i < 8) chk("fill_ok", rsp_status, 2'b00);
      else       chk("fill_overflow", rsp_status, 2'b01);
      consume();
    end
    send(2'b11, 4'h0); wait_rsp(lat); consume();

    // PUSH 1,2,3 then DRAIN
    for (int i = 1; i <= 3; i++) begin
      din_exp = 4'(i); send(2'b00, 4'(i)); wait_rsp(lat); consume();
    end
    send(2'b10, 4'h0);
    for (int i = 3; i >= 1; i--) begin
      wait_rsp(lat);
      chk("drain_data", rsp_data, 32'(i));
      chk("drain_status", rsp_status, 2'b00);
      chk("drain_last", rsp_last, (i == 1) ? 1 : 0);
      consume();
    end
    @(negedge clk);
    chk("drain_done_ready", cmd_ready, 1);
    en_cnt = 0;
    send(2'b10, 4'h0);
    wait_rsp(lat);
    chk("drain_empty_status", rsp_status, 2'b10);
    chk("drain_empty_data", rsp_data, 0);
    chk("drain_empty_last", rsp_last, 1);
    chk("drain_empty_no_en", en_cnt, 0);
    consume();

    // Reset during the enable pulse
    din_exp = 4'h9;
    send(2'b00, 4'h9);
    lat = 0;
    while (!stk_enable && lat < 20) begin @(negedge clk); lat++; end
    chk("abort_saw_pulse", stk_enable, 1);
    rst = 1'b1;
    #1;
    chk("abort_en_low", stk_enable, 0);
    chk("abort_stk_rst", stk_rst, 1);
    chk("abort_cmd_ready", cmd_ready, 0);
    rv_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", cmd_ready, 1);
    repeat (8) @(negedge clk);
    chk("abort_no_rsp", rv_cnt, 0);
    chk("never_push_and_pop", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
